prog_loader: RTL

- Writer side of the instruction memory that instruction fetch reads from.
- Accepts a byte stream (from a UART RX or debug bridge) carrying a program image.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the core in reset until the image is fully loaded and the checksum verifies, then releases it.

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side feeds bytes and observes the writes; the slave side is the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a framed little-endian image over a byte stream,
// writes it word by word into instruction memory from address 0, and releases
// the core from reset only after the XOR checksum matches.
module prog_loader #(
  parameter int IMEM_WORDS = 1024,
  parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CHK  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);

  state_t            state_q;
  logic [1:0]        byte_cnt_q;    // byte position inside header / current word
  logic [31:0]       n_q;           // header word count, then words still to receive
  logic [23:0]       shift_q;       // first three bytes of the word being assembled
  logic [7:0]        chk_q;         // running XOR of header and payload bytes
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              imem_we_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;

  logic              loading;
  logic              take;
  logic [31:0]       hdr_d;
  logic [31:0]       word_d;
  logic [7:0]        chk_d;

  assign loading      = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign bus.in_ready = loading & ~rst;
  assign take         = bus.in_valid & loading & ~rst;

  // Outputs are forced to their reset values during the rst cycle itself, so a
  // write strobe already registered cannot leak out once rst is asserted.
  assign bus.imem_we    = imem_we_q & ~rst;
  assign bus.imem_addr  = rst ? {ADDR_W{1'b0}} : imem_addr_q;
  assign bus.imem_wdata = rst ? 32'd0 : imem_wdata_q;
  assign bus.core_rst   = rst | core_rst_q;
  assign bus.done       = done_q & ~rst;
  assign bus.error      = error_q & ~rst;

  // Assemble the complete header value, the complete word and the next checksum
  // including the byte currently on the bus.
  always_comb begin
    hdr_d = n_q;
    case (byte_cnt_q)
      2'd0:    hdr_d[7:0]   = bus.in_data;
      2'd1:    hdr_d[15:8]  = bus.in_data;
      2'd2:    hdr_d[23:16] = bus.in_data;
      2'd3:    hdr_d[31:24] = bus.in_data;
      default: hdr_d        = n_q;
    endcase
    word_d = {bus.in_data, shift_q};
    chk_d  = chk_q ^ bus.in_data;
  end

  // Frame FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= 2'd0;
      n_q          <= 32'd0;
      shift_q      <= 24'd0;
      chk_q        <= 8'd0;
      word_idx_q   <= {ADDR_W{1'b0}};
      imem_addr_q  <= {ADDR_W{1'b0}};
      imem_wdata_q <= 32'd0;
      imem_we_q    <= 1'b0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (take) begin
            chk_q      <= chk_d;
            n_q        <= hdr_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              word_idx_q <= {ADDR_W{1'b0}};
              if (hdr_d > MAX_WORDS) begin
                state_q <= S_ERR;
                error_q <= 1'b1;
              end else if (hdr_d == 32'd0) begin
                state_q <= S_CHK;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (take) begin
            chk_q      <= chk_d;
            shift_q    <= {bus.in_data, shift_q[23:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_d;
              imem_addr_q  <= word_idx_q;
              word_idx_q   <= word_idx_q + ADDR_W'(1);
              n_q          <= n_q - 32'd1;
              if (n_q == 32'd1) begin
                state_q <= S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          if (take) begin
            if (bus.in_data == chk_q) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_ERR;
          error_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
